// File: rtl/bringup_pkg.sv
// bringup_pkg: mode encoding, pattern lengths and PIN_ID frame constants shared by the bringup image
package bringup_pkg;
    typedef enum logic [1:0] {
        MODE_FLASH  = 2'd0,
        MODE_WALK1  = 2'd1,
        MODE_WALK0  = 2'd2,
        MODE_PIN_ID = 2'd3
    } mode_t;
    localparam logic [2:0] ID_PREFIX = 3'b110;
    localparam logic ID_SUFFIX = 1'b0;
    localparam int unsigned ID_OVERHEAD = 4;
    function automatic int unsigned pattern_len(input mode_t m, input int unsigned width);
        return m == MODE_FLASH ? 32'd2 : m == MODE_PIN_ID ? 32'($clog2(width)) + ID_OVERHEAD : width;
    endfunction
endpackage

// File: rtl/bringup_prescaler.sv
// bringup_prescaler: free-running divider that pulses step every DIV enabled cycles
module bringup_prescaler #(
    parameter int DIV = 32768
) (
    input  logic clk_12mhz,
    input  logic reset_n,
    input  logic enable,
    output logic step
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    assign step = enable && cnt_q == CW'(DIV - 1);
    always_comb cnt_d = step ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk_12mhz or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/bringup_pattern.sv
// bringup_pattern: flash / walking-one / walking-zero / per-pin serial ID generator for board bringup
module bringup_pattern
    import bringup_pkg::*;
#(
    parameter int WIDTH = 160,
    parameter int DIV   = 32768
) (
    input  logic             clk_12mhz,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] pins,
    output logic [1:0]       active_mode,
    output logic             tick,
    output logic             wrap
);
    localparam int IDW = $clog2(WIDTH);
    localparam int FL  = IDW + ID_OVERHEAD;
    localparam int PW  = $clog2(WIDTH > FL ? WIDTH : FL);
    logic step;
    mode_t mode_q, mode_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [WIDTH-1:0] pins_q, pins_d;
    logic tick_q, wrap_q, wrap_d;
    bringup_prescaler #(.DIV(DIV)) u_prescaler (
        .clk_12mhz(clk_12mhz),
        .reset_n  (reset_n),
        .enable   (enable),
        .step     (step)
    );
    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        wrap_d = 1'b0;
        if (step) begin
            if (mode != mode_q) begin
                mode_d = mode_t'(mode);
                pos_d  = '0;
            end else if (32'(pos_q) == pattern_len(mode_q, WIDTH) - 1) begin
                pos_d  = '0;
                wrap_d = 1'b1;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        logic [FL-1:0] frame;
        logic [(2**PW)-1:0] slots;
        // bit s of slots is the frame bit sent in slot s
        assign frame = {<<{ID_PREFIX, IDW'(i), ID_SUFFIX}};
        assign slots = (2**PW)'(frame);
        assign pins_d[i] = mode_d == MODE_FLASH ? pos_d[0]
                         : mode_d == MODE_WALK1 ? pos_d == PW'(i)
                         : mode_d == MODE_WALK0 ? pos_d != PW'(i)
                         : slots[pos_d];
    end
    always_ff @(posedge clk_12mhz or negedge reset_n)
        if (!reset_n) begin
            mode_q <= MODE_FLASH;
            pos_q  <= '0;
            pins_q <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            pos_q  <= pos_d;
            pins_q <= pins_d;
            tick_q <= step;
            wrap_q <= wrap_d;
        end
    assign pins        = pins_q;
    assign active_mode = mode_q;
    assign tick        = tick_q;
    assign wrap        = wrap_q;
endmodule

// File: tb/tb_bringup_pattern.sv
// tb_bringup_pattern: directed steps queued as expectations, checked by a tick-driven monitor
module tb_bringup_pattern;
    typedef struct packed {
        logic [7:0] pins;
        logic [1:0] mode;
        logic       wrap;
    } exp_t;
    logic clk = 1'b0;
    logic reset_n, enable;
    logic [1:0] mode;
    logic [7:0] pins;
    logic [1:0] active_mode;
    logic tick, wrap;
    int checks = 0;
    int fails = 0;
    exp_t sb_q[$];
    always #5 clk = ~clk;
    bringup_pattern #(.WIDTH(8), .DIV(4)) dut (
        .clk_12mhz  (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .mode       (mode),
        .pins       (pins),
        .active_mode(active_mode),
        .tick       (tick),
        .wrap       (wrap)
    );
    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction
    task automatic expect_step(input logic [7:0] p, input logic [1:0] m, input logic w);
        exp_t e;
        int n;
        e.pins = p;
        e.mode = m;
        e.wrap = w;
        sb_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 40);
        if (!tick) check("tick_timeout", 32'd0, 32'd1);
    endtask
    // monitor: per-step expectations on tick, hold/quiet checks otherwise
    initial begin
        exp_t e;
        int en_cnt;
        logic [7:0] held_pins;
        logic [1:0] held_mode;
        en_cnt = 0;
        held_pins = 8'h00;
        held_mode = 2'd0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                en_cnt = 0;
                held_pins = 8'h00;
                held_mode = 2'd0;
            end else if (enable) en_cnt++;
            @(negedge clk);
            if (reset_n) begin
                if (tick) begin
                    check("tick_spacing", en_cnt, 4);
                    en_cnt = 0;
                    if (sb_q.size() == 0) check("unexpected_tick", 32'd1, 32'd0);
                    else begin
                        e = sb_q.pop_front();
                        check("step_pins", pins, e.pins);
                        check("step_mode", active_mode, e.mode);
                        check("step_wrap", wrap, e.wrap);
                        held_pins = e.pins;
                        held_mode = e.mode;
                    end
                end else begin
                    check("hold_pins", pins, held_pins);
                    check("hold_mode", active_mode, held_mode);
                    check("quiet_wrap", wrap, 0);
                end
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        logic [7:0] id_tab [7];
        id_tab = '{8'hFF, 8'hFF, 8'h00, 8'hF0, 8'hCC, 8'hAA, 8'h00};
        reset_n = 1'b0;
        enable = 1'b0;
        mode = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_pins", pins, 0);
        check("reset_mode", active_mode, 0);
        check("reset_tick", tick, 0);
        check("reset_wrap", wrap, 0);
        reset_n = 1'b1;
        enable = 1'b1;
        expect_step(8'hFF, 2'd0, 1'b0);
        expect_step(8'h00, 2'd0, 1'b1);
        expect_step(8'hFF, 2'd0, 1'b0);
        mode = 2'd1;
        expect_step(8'h01, 2'd1, 1'b0);
        for (int k = 1; k < 8; k++) expect_step(8'(1 << k), 2'd1, 1'b0);
        expect_step(8'h01, 2'd1, 1'b1);
        expect_step(8'h02, 2'd1, 1'b0);
        expect_step(8'h04, 2'd1, 1'b0);
        expect_step(8'h08, 2'd1, 1'b0);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        expect_step(8'h10, 2'd1, 1'b0);
        expect_step(8'h20, 2'd1, 1'b0);
        expect_step(8'h40, 2'd1, 1'b0);
        expect_step(8'h80, 2'd1, 1'b0);
        mode = 2'd0;
        expect_step(8'h00, 2'd0, 1'b0);
        mode = 2'd2;
        expect_step(8'hFE, 2'd2, 1'b0);
        mode = 2'd3;
        @(negedge clk);
        mode = 2'd2;
        expect_step(8'hFD, 2'd2, 1'b0);
        for (int k = 2; k < 8; k++) expect_step(~8'(1 << k), 2'd2, 1'b0);
        expect_step(8'hFE, 2'd2, 1'b1);
        mode = 2'd3;
        for (int k = 0; k < 7; k++) expect_step(id_tab[k], 2'd3, 1'b0);
        expect_step(8'hFF, 2'd3, 1'b1);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_pins", pins, 0);
        check("async_reset_mode", active_mode, 0);
        check("async_reset_tick", tick, 0);
        check("async_reset_wrap", wrap, 0);
        @(negedge clk);
        mode = 2'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        expect_step(8'hFF, 2'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
